// File: rtl/debounce_ctrl_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and a
// constant-width helper.
package debounce_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_LONG  = 2'd2
   } state_t;

   // Bits needed to hold values 0..value-1 (minimum 1).
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_ctrl_tick_gen.sv
// Free-running divider: one-cycle strobe every SAMPLE_DIV clocks. Also usable
// for display scan timing.
module tick_gen
   import debounce_ctrl_pkg::*;
#(
   parameter int SAMPLE_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_tick
);

   localparam int CW = clog2(SAMPLE_DIV);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/debounce_ctrl.sv
// Push-button conditioner: 2-FF synchroniser, sampled shift-window filter and
// an IDLE/PRESS/LONG FSM that flags long presses.
module debounce_ctrl
   import debounce_ctrl_pkg::*;
#(
   parameter int SAMPLE_DIV = 100000,
   parameter int DEPTH      = 4,
   parameter int HOLD_TICKS = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_pb_raw,
   output logic       o_pb_debounced,
   output logic       o_long_press,
   output logic       o_sample_tick,
   output logic [1:0] o_dbg_state
);

   localparam int HW = clog2(HOLD_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

   logic             w_tick;
   logic [DEPTH-1:0] w_win_next;
   logic             r_s1;
   logic             r_s2;
   logic [DEPTH-1:0] r_win;
   logic             r_level;
   logic             r_long;
   logic [HW-1:0]    r_hold;
   state_t           r_state;

   tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .o_tick(w_tick)
   );

   assign w_win_next = {r_win[DEPTH-2:0], r_s2};

   // Level follows the window only when every sample agrees; mixed windows hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_win   <= '0;
         r_level <= 1'b0;
      end else begin
         r_s1 <= i_pb_raw;
         r_s2 <= r_s1;
         if (w_tick) begin
            r_win <= w_win_next;
            if (&w_win_next) begin
               r_level <= 1'b1;
            end else if (~|w_win_next) begin
               r_level <= 1'b0;
            end
         end
      end
   end

   // Release is tested before the hold-count tick so it always wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_hold  <= '0;
         r_long  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_hold <= '0;
               r_long <= 1'b0;
               if (r_level) r_state <= ST_PRESS;
            end
            ST_PRESS: begin
               if (!r_level) begin
                  r_state <= ST_IDLE;
                  r_hold  <= '0;
               end else if (w_tick) begin
                  r_hold <= r_hold + HW'(1);
                  if (r_hold == HOLD_LAST) begin
                     r_state <= ST_LONG;
                     r_long  <= 1'b1;
                  end
               end
            end
            ST_LONG: begin
               if (!r_level) begin
                  r_state <= ST_IDLE;
                  r_hold  <= '0;
                  r_long  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_hold  <= '0;
               r_long  <= 1'b0;
            end
         endcase
      end
   end

   assign o_pb_debounced = r_level;
   assign o_long_press   = r_long;
   assign o_sample_tick  = w_tick;
   assign o_dbg_state    = r_state;

endmodule
